// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
package seq_detect_pkg;

    // Pattern, length and overlap mode loaded at reset.
    localparam logic [15:0] SEQ_DEF_PATTERN = 16'b10010;
    localparam int          SEQ_DEF_LEN     = 5;
    localparam bit          SEQ_DEF_OVERLAP = 1'b1;

    // Width needed to hold a pattern length of 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a clear on the same edge as an
// increment leaves the count at one.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Reset wins, then clear (counting the coincident increment), then saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector. The newest bit enters hist at bit 0.
// A detection is a masked compare of the low len bits of the shifted history
// against the active pattern, qualified by enough history having been seen.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int          MAX_LEN     = 8,
    parameter int          CNT_W       = 8,
    parameter logic [15:0] DEF_PATTERN = SEQ_DEF_PATTERN,
    parameter int          DEF_LEN     = SEQ_DEF_LEN,
    parameter bit          DEF_OVERLAP = SEQ_DEF_OVERLAP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_bit,
    input  logic                       cfg_load,
    input  logic [MAX_LEN-1:0]         cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]  cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       cnt_clr,
    output logic                       match,
    output logic [CNT_W-1:0]           match_count,
    output logic [len_w(MAX_LEN)-1:0]  fill
);

    localparam int LEN_W = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;

    logic [MAX_LEN-1:0] shifted;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   len_clamped;
    logic               detect;

    // Length clamp applied when a new configuration is latched.
    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // Masked compare of the would-be history against the pattern; a load
    // cycle never detects because its input bit is discarded.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len)) begin
                mask[i] = 1'b1;
            end
        end
        shifted  = (hist << 1) | MAX_LEN'(in_bit);
        fill_inc = {1'b0, fill} + (LEN_W + 1)'(1);
        detect   = in_valid && !cfg_load
                   && ((shifted & mask) == (pattern & mask))
                   && (fill_inc >= {1'b0, len});
    end

    // Configuration, history, fill and the registered match pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= DEF_PATTERN[MAX_LEN-1:0];
            len     <= LEN_W'(DEF_LEN);
            overlap <= DEF_OVERLAP;
            hist    <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= len_clamped;
            overlap <= cfg_overlap;
            hist    <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else begin
            match <= detect;
            if (in_valid) begin
                hist <= shifted;
                // Non-overlapping mode restarts the fresh-bit count after a hit.
                if (detect && !overlap) begin
                    fill <= '0;
                end else if (fill < len) begin
                    fill <= fill + LEN_W'(1);
                end
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (detect),
        .count(match_count)
    );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench: two detectors (wide and 2-bit counters) share stimulus;
// a behavioural model pushes the expected post-edge outputs, and a monitor
// pops and compares them on the falling edge.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_bit = 1'b0;
    logic                 cfg_load = 1'b0;
    logic [MAX_LEN-1:0]   cfg_pattern = '0;
    logic [LEN_W-1:0]     cfg_len = '0;
    logic                 cfg_overlap = 1'b0;
    logic                 cnt_clr = 1'b0;

    logic                 match_a, match_b;
    logic [7:0]           count_a;
    logic [1:0]           count_b;
    logic [LEN_W-1:0]     fill_a, fill_b;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match_a), .match_count(count_a), .fill(fill_a)
    );

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match_b), .match_count(count_b), .fill(fill_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit m;
        int c8;
        int c2;
        int f;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: the whole received bit sequence since the last
    // clear, and how many bits arrived since the last clear/non-overlap hit.
    bit   mh[$];
    int   m_fresh;
    bit [MAX_LEN-1:0] m_pat;
    int   m_len;
    bit   m_ov;
    int   m_c8, m_c2;

    task automatic model_reset();
        mh.delete();
        m_fresh = 0;
        m_pat   = 8'b0001_0010;
        m_len   = 5;
        m_ov    = 1'b1;
        m_c8    = 0;
        m_c2    = 0;
    endtask

    task automatic model_edge(input bit r, input bit v, input bit b, input bit ld,
                              input bit [MAX_LEN-1:0] pat, input int ln, input bit ov,
                              input bit clr);
        exp_t e;
        bit   det;
        det = 1'b0;
        if (r) begin
            model_reset();
        end else if (ld) begin
            m_pat   = pat;
            m_len   = (ln == 0) ? 1 : ((ln > MAX_LEN) ? MAX_LEN : ln);
            m_ov    = ov;
            mh.delete();
            m_fresh = 0;
            if (clr) begin
                m_c8 = 0;
                m_c2 = 0;
            end
        end else begin
            if (v) begin
                mh.push_back(b);
                if (mh.size() > 2 * MAX_LEN) void'(mh.pop_front());
                m_fresh++;
                if (m_fresh >= m_len) begin
                    // Most recent bit must equal pat[0], the one before pat[1], ...
                    det = 1'b1;
                    for (int k = 0; k < m_len; k++) begin
                        if (mh[mh.size() - 1 - k] != m_pat[k]) det = 1'b0;
                    end
                end
                if (det && !m_ov) m_fresh = 0;
            end
            if (clr) begin
                m_c8 = det ? 1 : 0;
                m_c2 = det ? 1 : 0;
            end else if (det) begin
                m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
                m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
            end
        end
        e.m  = det;
        e.c8 = m_c8;
        e.c2 = m_c2;
        e.f  = (m_fresh < m_len) ? m_fresh : m_len;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, let the edge happen, then record the expectation.
    task automatic step(input bit r, input bit v, input bit b, input bit ld,
                        input bit [MAX_LEN-1:0] pat, input int ln, input bit ov,
                        input bit clr);
        rst         = r;
        in_valid    = v;
        in_bit      = b;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(ln);
        cfg_overlap = ov;
        cnt_clr     = clr;
        @(posedge clk);
        model_edge(r, v, b, ld, pat, ln, ov, clr);
        #1;
    endtask

    task automatic bit_in(input bit b, input bit clr = 1'b0);
        step(1'b0, 1'b1, b, 1'b0, '0, 0, 1'b0, clr);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_load(input bit [MAX_LEN-1:0] pat, input int ln, input bit ov);
        step(1'b0, 1'b0, 1'b0, 1'b1, pat, ln, ov, 1'b0);
    endtask

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: every recorded edge produces one expectation, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("match_a", int'(match_a), int'(e.m));
            check("match_b", int'(match_b), int'(e.m));
            check("count_a", int'(count_a), e.c8);
            check("count_b", int'(count_b), e.c2);
            check("fill_a",  int'(fill_a),  e.f);
            check("fill_b",  int'(fill_b),  e.f);
        end
    end

    initial begin
        bit [7:0] s1;
        bit [10:0] s2;
        int       waited;
        s1 = 8'b1001_0010;
        s2 = 11'b100_1001_0010;
        model_reset();

        do_reset();
        do_reset();

        // Default pattern 10010 overlapping: hits after bits 5 and 8.
        for (int i = 7; i >= 0; i--) bit_in(s1[i]);
        // Gap cycles hold state.
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);

        // Non-overlapping: one hit only.
        do_load(8'b0001_0010, 5, 1'b0);
        for (int i = 7; i >= 0; i--) bit_in(s1[i]);

        // cnt_clr coinciding with the third detection leaves count at 1.
        do_reset();
        for (int i = 10; i >= 0; i--) bit_in(s2[i], (i == 0));

        // Length-1 pattern: six hits, 2-bit counter saturates at 3.
        do_load(8'b0000_0001, 1, 1'b1);
        for (int i = 0; i < 6; i++) bit_in(1'b1);

        // cfg_len 0 clamps to 1; pattern bit0 = 1.
        do_load(8'b1010_0101, 0, 1'b0);
        bit_in(1'b0);
        bit_in(1'b1);

        // Oversized length clamps to MAX_LEN; load with a valid bit discards it.
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'b1111_1111, 15, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) bit_in(1'b1);

        // Reset mid-stream aborts a partial match.
        do_reset();
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1, 1'b0, 1'b1);
        bit_in(1'b0);

        // Randomized traffic with short patterns so detections are frequent.
        for (int n = 0; n < 600; n++) begin
            bit r, v, ld, clr, ov;
            bit [MAX_LEN-1:0] pat;
            int ln;
            r   = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 29) == 0);
            v   = ($urandom_range(0, 9) < 7);
            ov  = $urandom_range(0, 1);
            pat = MAX_LEN'($urandom);
            ln  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
            step(r, v, 1'($urandom), ld, pat, ln, ov, clr);
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
